// File: rtl/uart_tx_controller_if.sv
// UART slave register bus: control/data register select with active-low strobes.
// The controller drives the strobes and write data; the UART returns read data and a stall.
interface uart_tx_controller_if;
  logic [31:0] readdata_in;
  logic        waitrequest_in;
  logic        chipselect_out;
  logic        address_out;
  logic        read_n_out;
  logic        write_n_out;
  logic [31:0] writedata_out;

  modport master (
    input  readdata_in, waitrequest_in,
    output chipselect_out, address_out, read_n_out, write_n_out, writedata_out
  );

  modport slave (
    output readdata_in, waitrequest_in,
    input  chipselect_out, address_out, read_n_out, write_n_out, writedata_out
  );
endinterface

// File: rtl/uart_tx_controller.sv
// Streams 16-bit memory words to a UART as bytes (low byte first), polling WSPACE before each byte.
// Latency: 6 cycles per word minimum (FETCH, LATCH, 2x POLL+SEND); done pulses one cycle after the last byte.
// Backpressure: bus strobes/data are held while waitrequest is high; WSPACE=0 retries the poll after a 1-cycle gap.
module uart_tx_controller #(
  parameter int ADDRESS_WIDTH = 11
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     start_in,
  input  logic [ADDRESS_WIDTH-1:0] start_address_in,
  input  logic [ADDRESS_WIDTH:0]   word_count_in,
  input  logic [15:0]              memory_data_in,
  output logic [ADDRESS_WIDTH-1:0] memory_address_out,
  uart_tx_controller_if.master     uart,
  output logic                     busy_out,
  output logic                     done_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    POLL  = 3'd3,
    SEND  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [ADDRESS_WIDTH:0] COUNT_ONE = (ADDRESS_WIDTH + 1)'(1);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH:0]   count_q;
  logic [15:0]              word_q;
  logic                     byte_idx;
  logic                     poll_gap;
  logic                     cs_q;
  logic                     reg_sel_q;
  logic                     read_n_q;
  logic                     write_n_q;
  logic [31:0]              wdata_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     wspace_ok;
  logic                     unused_rd;

  assign wspace_ok = |uart.readdata_in[31:16];
  assign unused_rd = ^uart.readdata_in[15:0];

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state     <= IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      word_q    <= '0;
      byte_idx  <= 1'b0;
      poll_gap  <= 1'b0;
      cs_q      <= 1'b0;
      reg_sel_q <= 1'b0;
      read_n_q  <= 1'b1;
      write_n_q <= 1'b1;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            addr_q  <= start_address_in;
            count_q <= word_count_in;
            if (word_count_in == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= FETCH;
              busy_q <= 1'b1;
            end
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          word_q    <= memory_data_in;
          byte_idx  <= 1'b0;
          poll_gap  <= 1'b0;
          state     <= POLL;
          cs_q      <= 1'b1;
          reg_sel_q <= 1'b1;
          read_n_q  <= 1'b0;
        end
        POLL: begin
          // A zero WSPACE drops the strobes for one cycle before re-reading control.
          if (poll_gap) begin
            poll_gap <= 1'b0;
            cs_q     <= 1'b1;
            read_n_q <= 1'b0;
          end else if (!uart.waitrequest_in) begin
            read_n_q <= 1'b1;
            if (wspace_ok) begin
              state     <= SEND;
              reg_sel_q <= 1'b0;
              write_n_q <= 1'b0;
              wdata_q   <= {24'h0, byte_idx ? word_q[15:8] : word_q[7:0]};
            end else begin
              cs_q     <= 1'b0;
              poll_gap <= 1'b1;
            end
          end
        end
        SEND: begin
          if (!uart.waitrequest_in) begin
            write_n_q <= 1'b1;
            wdata_q   <= '0;
            if (!byte_idx) begin
              byte_idx  <= 1'b1;
              state     <= POLL;
              reg_sel_q <= 1'b1;
              read_n_q  <= 1'b0;
            end else begin
              cs_q      <= 1'b0;
              reg_sel_q <= 1'b0;
              byte_idx  <= 1'b0;
              addr_q    <= addr_q + 1'b1;
              count_q   <= count_q - 1'b1;
              if (count_q == COUNT_ONE) begin
                state  <= DONE;
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end else begin
                state <= FETCH;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign memory_address_out  = addr_q;
  assign uart.chipselect_out = cs_q;
  assign uart.address_out    = reg_sel_q;
  assign uart.read_n_out     = read_n_q;
  assign uart.write_n_out    = write_n_q;
  assign uart.writedata_out  = wdata_q;
  assign busy_out            = busy_q;
  assign done_out            = done_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Scoreboard bench: stimulus pushes expected bytes and done cycles; negedge monitors pop and compare.
module tb_uart_tx_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_in = 1'b0;
  logic [10:0] start_address = '0;
  logic [11:0] word_count = '0;
  logic [15:0] memory_data = '0;
  logic [10:0] memory_address;
  logic        busy, done;

  uart_tx_controller_if bus ();

  uart_tx_controller #(.ADDRESS_WIDTH(11)) dut (
    .clock_in          (clk),
    .reset_in          (rst),
    .start_in          (start_in),
    .start_address_in  (start_address),
    .word_count_in     (word_count),
    .memory_data_in    (memory_data),
    .memory_address_out(memory_address),
    .uart              (bus),
    .busy_out          (busy),
    .done_out          (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_exp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rd_start = 0;
  int hold_cnt = 0;
  int hold_target = 0;
  int wsp_len = 0;
  logic [15:0] wsp [0:7];
  logic [15:0] ws_now;
  logic [15:0] last_ws = '0;
  logic [15:0] mem [0:2047];
  wr_exp_t exp_wr[$];
  int exp_done[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) memory_data <= mem[memory_address];

  // UART slave model: scheduled WSPACE values per control read, optional write stalls.
  always_comb begin
    ws_now = 16'h0040;
    if (rd_cnt - rd_start < wsp_len) ws_now = wsp[rd_cnt - rd_start];
  end
  assign bus.readdata_in    = {ws_now, 16'h0000};
  assign bus.waitrequest_in = bus.chipselect_out && !bus.write_n_out && (hold_cnt < hold_target);

  always @(posedge clk) begin
    if (bus.chipselect_out && !bus.read_n_out && !bus.waitrequest_in) rd_cnt <= rd_cnt + 1;
    if (bus.chipselect_out && !bus.write_n_out && bus.waitrequest_in) hold_cnt <= hold_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Monitors
  logic [35:0] prev_snap = '0;
  logic        prev_stall = 1'b0;
  logic        prev_rst = 1'b1;

  always @(negedge clk) begin
    logic [35:0] snap;
    wr_exp_t e;
    int dc;
    snap = {bus.chipselect_out, bus.address_out, bus.read_n_out, bus.write_n_out, bus.writedata_out};
    if (!bus.read_n_out || !bus.write_n_out) begin
      chk("strobes_exclusive", {31'h0, bus.read_n_out | bus.write_n_out}, 1);
      chk("cs_with_strobe", {31'h0, bus.chipselect_out}, 1);
    end
    if (prev_stall && !prev_rst) chk("stable_under_wait", snap, prev_snap);
    if (bus.chipselect_out && !bus.read_n_out && !bus.waitrequest_in) last_ws = bus.readdata_in[31:16];
    if (bus.chipselect_out && !bus.write_n_out && !bus.waitrequest_in) begin
      if (exp_wr.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write actual=0x%0h required=none", bus.writedata_out);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_data", bus.writedata_out, {24'h0, e.data});
        chk("wr_mem_addr", {21'h0, memory_address}, {21'h0, e.addr});
        chk("wr_reg_sel", {31'h0, bus.address_out}, 0);
        chk("wspace_before_write", {31'h0, last_ws != 16'h0}, 1);
      end
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done actual=cycle %0d required=none", cyc);
      end else begin
        dc = exp_done.pop_front();
        chk("done_cycle", cyc, dc);
        chk("busy_at_done", {31'h0, busy}, 0);
      end
    end
    prev_stall = bus.chipselect_out && bus.waitrequest_in && (!bus.read_n_out || !bus.write_n_out);
    prev_snap  = snap;
    prev_rst   = rst;
  end

  // Stimulus
  task automatic pulse_start(input logic [10:0] a, input logic [11:0] n, output int s);
    @(posedge clk); #1;
    start_in = 1'b1; start_address = a; word_count = n; s = cyc;
    @(posedge clk); #1;
    start_in = 1'b0;
  endtask

  task automatic xfer(input logic [10:0] a, input logic [11:0] n, input int extra);
    int s;
    logic [10:0] wa;
    for (int i = 0; i < int'(n); i++) begin
      wa = a + 11'(i);
      exp_wr.push_back('{addr: wa, data: mem[wa][7:0]});
      exp_wr.push_back('{addr: wa, data: mem[wa][15:8]});
    end
    pulse_start(a, n, s);
    exp_done.push_back(s + 1 + 6 * int'(n) + extra);
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (exp_done.size() != 0 && t < 300) begin
      @(negedge clk); t++;
    end
    if (exp_done.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no done required=done", nm);
      exp_done.delete();
    end
    repeat (4) @(negedge clk);
    chk({nm, "_busy_after"}, {31'h0, busy}, 0);
    chk({nm, "_writes_left"}, exp_wr.size(), 0);
  endtask

  initial begin
    int s;
    int t;
    int h0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
    mem[11'h010] = 16'h41AD;
    mem[11'h7FF] = 16'h1234;
    mem[11'h000] = 16'h5678;
    mem[11'h001] = 16'h9ABC;
    for (int i = 0; i < 8; i++) wsp[i] = 16'h0040;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cs", {31'h0, bus.chipselect_out}, 0);
    chk("rst_read_n", {31'h0, bus.read_n_out}, 1);
    chk("rst_write_n", {31'h0, bus.write_n_out}, 1);
    chk("rst_reg_sel", {31'h0, bus.address_out}, 0);
    chk("rst_wdata", bus.writedata_out, 0);
    chk("rst_mem_addr", {21'h0, memory_address}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);

    // Single word, no stalls: bytes AD then 41, done 7 cycles after start.
    rd_start = rd_cnt;
    xfer(11'h010, 12'd1, 0);
    @(negedge clk);
    chk("busy_during", {31'h0, busy}, 1);
    wait_done("one_word");
    chk("one_word_reads", rd_cnt - rd_start, 2);

    // Address wrap across the top of memory.
    rd_start = rd_cnt;
    xfer(11'h7FF, 12'd3, 0);
    wait_done("wrap");
    chk("wrap_reads", rd_cnt - rd_start, 6);

    // WSPACE 0, 0, then 1: two retries costing two cycles each.
    wsp[0] = 16'h0000; wsp[1] = 16'h0000; wsp[2] = 16'h0001;
    wsp_len = 3;
    rd_start = rd_cnt;
    xfer(11'h100, 12'd1, 4);
    wait_done("wspace");
    chk("wspace_reads", rd_cnt - rd_start, 4);
    wsp_len = 0;

    // Three wait states on the first data write.
    h0 = hold_cnt;
    hold_target = hold_cnt + 3;
    xfer(11'h200, 12'd1, 3);
    wait_done("stall");
    chk("stall_cycles", hold_cnt - h0, 3);

    // Zero count: no bus access, done next cycle.
    rd_start = rd_cnt;
    xfer(11'h300, 12'd0, 0);
    wait_done("zero");
    chk("zero_reads", rd_cnt - rd_start, 0);

    // Start while busy is ignored.
    rd_start = rd_cnt;
    xfer(11'h040, 12'd2, 0);
    repeat (3) @(posedge clk);
    pulse_start(11'h050, 12'd1, s);
    wait_done("ignore_start");
    chk("ignore_start_reads", rd_cnt - rd_start, 4);

    // Reset during a stalled write; the aborted transfer must not resume.
    hold_target = hold_cnt + 1000;
    pulse_start(11'h020, 12'd1, s);
    t = 0;
    while (!(bus.chipselect_out && !bus.write_n_out) && t < 60) begin
      @(negedge clk); t++;
    end
    chk("reached_send_stall", {31'h0, bus.waitrequest_in}, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    hold_target = hold_cnt;
    @(negedge clk);
    chk("abort_cs", {31'h0, bus.chipselect_out}, 0);
    chk("abort_write_n", {31'h0, bus.write_n_out}, 1);
    chk("abort_read_n", {31'h0, bus.read_n_out}, 1);
    chk("abort_busy", {31'h0, busy}, 0);
    repeat (12) @(negedge clk);
    chk("abort_stays_idle", {31'h0, busy}, 0);
    rd_start = rd_cnt;
    xfer(11'h030, 12'd1, 0);
    wait_done("after_reset");
    chk("after_reset_reads", rd_cnt - rd_start, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_tx_controller.md
UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Interface
REQ-001 SHALL have parameter: ADDRESS_WIDTH, default 11, width of the instruction-memory address.
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports named as below.
REQ-003 clock_in  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 start_in  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 start_address_in  input  ADDRESS_WIDTH  first memory word of the transfer; sampled with start_in.
REQ-007 word_count_in  input  ADDRESS_WIDTH+1  number of 16-bit words to send; sampled with start_in.
REQ-008 memory_data_in  input  16  memory read-port data; valid one cycle after memory_address_out is presented.
REQ-009 memory_address_out  output  ADDRESS_WIDTH  memory read address.
REQ-010 readdata_in  input  32  UART slave read data.
REQ-011 waitrequest_in  input  1  UART slave stall; an access completes in the first cycle it is low.
REQ-012 chipselect_out  output  1  UART slave select.
REQ-013 address_out  output  1  UART register select: 0 = data, 1 = control.
REQ-014 read_n_out  output  1  active-low read strobe.
REQ-015 write_n_out  output  1  active-low write strobe.
REQ-016 writedata_out  output  32  UART write data; bits [7:0] = byte, [31:8] = 0.
REQ-017 busy_out  output  1  high from the start acceptance until done.
REQ-018 done_out  output  1  one-cycle pulse when a transfer finishes.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, LATCH, POLL, SEND, DONE.
REQ-020 IDLE: on start_in=1, latch the address and count, then go to FETCH, or go to DONE if the count is 0; start_in SHALL be ignored in every other state.
REQ-021 FETCH: drive memory_address_out = current address for one cycle, then go to LATCH.
REQ-022 LATCH: capture memory_data_in into the word register, set byte index = 0, then go to POLL.
REQ-023 POLL: hold chipselect=1, address=1, read_n=0 until waitrequest_in=0.
REQ-024 POLL completion, WSPACE (readdata_in[31:16]) nonzero: go to SEND.
REQ-025 POLL completion, WSPACE zero: deassert strobes for one cycle, then re-enter POLL.
REQ-026 SEND: hold chipselect=1, address=0, write_n=0, writedata = selected byte until waitrequest_in=0.
REQ-027 Byte order SHALL be word[7:0] first (index 0), then word[15:8] (index 1).
REQ-028 SEND completion at index 0: set index = 1 and go to POLL.
REQ-029 SEND completion at index 1, words remaining: increment the address, decrement the count, and go to FETCH if the count is still nonzero.
REQ-030 SEND completion at index 1, last word (count reaches 0): go to DONE.
REQ-031 The address SHALL wrap modulo 2^ADDRESS_WIDTH.
REQ-032 DONE: done_out=1 for exactly one cycle, busy_out=0, then go to IDLE.
REQ-033 read_n_out and write_n_out SHALL never be low in the same cycle.
REQ-034 Both strobes SHALL be high, and chipselect_out low, outside POLL/SEND.
REQ-035 Strobes and data SHALL stay constant while waitrequest_in=1.
REQ-036 busy_out SHALL be 1 in FETCH, LATCH, POLL and SEND.
REQ-037 Steady-state minimum latency per word, with waitrequest low and WSPACE > 0: FETCH + LATCH + 2×(POLL + SEND) = 6 cycles.

Reset
REQ-038 reset_in=1 SHALL force IDLE from any state, including mid-access.
REQ-039 On reset, at the next edge: chipselect=0, read_n=1, write_n=1, address_out=0, writedata=0, memory_address=0, busy=0, done=0, count=0, byte index=0.
REQ-040 A transfer interrupted by reset SHALL NOT resume.

Verification
REQ-041 Start at address 0x010, count 1, memory[0x010]=0x41AD, WSPACE=0x0040, no wait states -> data writes 0xAD then 0x41, done pulse on the 7th cycle after start, busy low afterwards.
REQ-042 Count 3 starting at 0x7FF (ADDRESS_WIDTH=11) -> memory_address sequence 0x7FF, 0x000, 0x001; 6 bytes written in order.
REQ-043 Control read returns WSPACE=0 twice, then 0x0001 -> three control reads, one idle cycle between them, then the data write; no data write while WSPACE=0.
REQ-044 waitrequest held high 3 cycles on a SEND -> chipselect, address, write_n and writedata stable all 4 cycles; exactly one byte accepted.
REQ-045 Count 0 -> no bus access, done pulse the cycle after start; start_in pulsed while busy -> ignored, count unchanged.
REQ-046 reset_in asserted during SEND with waitrequest high -> next cycle strobes high, busy 0, state IDLE; a new start then runs normally.
